// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage for sync_fifo: synchronous write port and a registered
// read port with read-enable. The array itself is never reset.
module sync_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read stage: output register resets so rd_data is defined out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy count and flags around sync_fifo_mem.
// Flags come only from the registered count, never from wr_en/rd_en.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  output logic                  full,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_fire;
  logic                  rd_fire;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  // Pointers wrap naturally at DEPTH since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_fire) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      case ({wr_fire, rd_fire})
        2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  sync_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: table-driven vectors plus a scoreboard
// queue that predicts rd_data, count and flags on every clock.
module tb_sync_fifo;

  localparam int W = 32;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         full;
  logic         empty;
  logic [W-1:0] rd_data;
  logic [4:0]   count;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] q [$];
  logic [W-1:0] exp_rd = '0;
  string        phase = "reset";

  typedef struct {
    logic         w;
    logic [W-1:0] d;
    logic         r;
    int           cnt;
  } vec_t;

  vec_t tbl [16];

  sync_fifo #(.WIDTH(W), .DEPTH(D)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got %h want %h", phase, name, act, exp);
    end
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge state.
  task automatic step(input logic w, input logic [W-1:0] d, input logic r);
    bit wf;
    bit rf;
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    wf = w && (q.size() < D);
    rf = r && (q.size() > 0);
    if (rf) exp_rd = q.pop_front();
    if (wf) q.push_back(d);
    @(posedge clk);
    #1;
    chk("rd_data", rd_data, exp_rd);
    chk("count", W'(count), W'(q.size()));
    chk("empty", W'(empty), W'(q.size() == 0));
    chk("full", W'(full), W'(q.size() == D));
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    // Test 1: reset held for 5 clocks
    repeat (5) @(posedge clk);
    #1;
    chk("rst_empty", W'(empty), 32'd1);
    chk("rst_full", W'(full), 32'd0);
    chk("rst_count", W'(count), 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    rst_n = 1'b1;

    // Test 2: table of 8 writes then 8 reads with independent count expectations
    phase = "basic";
    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{w: 1'b1, d: 32'hDEADBEE0 + W'(i), r: 1'b0, cnt: i + 1};
      tbl[i + 8] = '{w: 1'b0, d: '0, r: 1'b1, cnt: 7 - i};
    end
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r);
      chk("tbl_count", W'(count), W'(tbl[i].cnt));
      if (i >= 8) chk("tbl_rd_data", rd_data, 32'hDEADBEE0 + W'(i - 8));
    end
    chk("basic_empty", W'(empty), 32'd1);
    step(1'b0, '0, 1'b1);
    chk("rd_on_empty_holds", rd_data, 32'hDEADBEE7);

    // Test 3: fill to full, overflow write ignored, drain
    phase = "full";
    for (int i = 0; i < 16; i++) step(1'b1, 32'hCAFE0000 + W'(i), 1'b0);
    chk("full_flag", W'(full), 32'd1);
    chk("full_count", W'(count), 32'd16);
    step(1'b1, 32'h0BAD0BAD, 1'b0);
    chk("overflow_count", W'(count), 32'd16);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, '0, 1'b1);
      chk("drain_order", rd_data, 32'hCAFE0000 + W'(i));
    end
    chk("drain_count", W'(count), 32'd0);

    // Test 4: simultaneous read/write keeps count steady
    phase = "simul";
    for (int i = 0; i < 8; i++) step(1'b1, 32'hABCD0000 + W'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'hEF000000 + W'(i), 1'b1);
      chk("simul_count", W'(count), 32'd8);
    end
    for (int i = 0; i < 8; i++) step(1'b0, '0, 1'b1);
    chk("simul_last", rd_data, 32'hEF000004);
    // Both requested while full: only the read proceeds
    for (int i = 0; i < 16; i++) step(1'b1, 32'h11110000 + W'(i), 1'b0);
    step(1'b1, 32'h22222222, 1'b1);
    chk("full_both_count", W'(count), 32'd15);
    for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);
    // Both requested while empty: only the write proceeds, no write-through
    step(1'b1, 32'h33333333, 1'b1);
    chk("empty_both_rd", rd_data, 32'h1111000F);
    chk("empty_both_count", W'(count), 32'd1);
    step(1'b0, '0, 1'b1);

    // Test 5: wrap-around
    phase = "wrap";
    for (int i = 0; i < 16; i++) step(1'b1, 32'h5A000000 + W'(i), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h5B000000 + W'(i), 1'b0);
    chk("wrap_count", W'(count), 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
    chk("wrap_last", rd_data, 32'h5B000009);

    // Test 6: random traffic against the scoreboard
    phase = "random";
    for (int i = 0; i < 100; i++) begin
      step(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
    end
    while (q.size() > 0) step(1'b0, '0, 1'b1);

    // Reset mid-operation discards contents, asynchronously
    phase = "midreset";
    for (int i = 0; i < 5; i++) step(1'b1, 32'h77000000 + W'(i), 1'b0);
    step(1'b0, '0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", W'(count), 32'd0);
    chk("async_empty", W'(empty), 32'd1);
    chk("async_rd_data", rd_data, 32'd0);
    q.delete();
    exp_rd = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'h88888888, 1'b0);
    step(1'b0, '0, 1'b1);
    chk("post_reset_data", rd_data, 32'h88888888);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
